// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop sync, per-bit stability count on a prescaled tick, change events into a small queue.
// Latency: 2 cycles sync plus STABLE_TICKS-1..STABLE_TICKS tick periods to state_o; the event follows 1+ cycles later.
// Backpressure: evt_valid/evt_ready on the queue head; a push into a full queue is dropped and sets sticky overflow.
module sw_debounce #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sw,
    output logic [WIDTH-1:0]         state_o,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(WIDTH)-1:0] evt_index,
    output logic                     evt_level,
    output logic                     overflow,
    input  logic                     clear_ovf
);
    localparam int IW = $clog2(WIDTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [CW-1:0]    stab [WIDTH];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] plev;
    logic [WIDTH-1:0] pend_clr;
    logic             push_vld;
    logic [IW-1:0]    push_idx;
    logic             push_lvl;
    logic             push_ok;
    logic             drop;
    logic             pop;

    logic [IW-1:0]         mem_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_lvl;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            pre_cnt <= '0;
        end else begin
            sync1   <= sw;
            sync2   <= sync1;
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    // A bit is accepted on the tick where its run of disagreeing samples reaches STABLE_TICKS.
    always_comb begin
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc[i] = tick && (sync2[i] != state_o[i]) && (stab[i] == STAB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_o <= '0;
            pend    <= '0;
            plev    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                stab[i] <= '0;
            end
        end else begin
            pend <= (pend & ~pend_clr) | acc;
            if (tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync2[i] == state_o[i]) begin
                        stab[i] <= '0;
                    end else if (acc[i]) begin
                        state_o[i] <= sync2[i];
                        plev[i]    <= sync2[i];
                        stab[i]    <= '0;
                    end else begin
                        stab[i] <= stab[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Lowest pending index wins; scanning downward leaves the smallest set index in push_idx.
    always_comb begin
        push_vld = 1'b0;
        push_idx = '0;
        pend_clr = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                push_vld = 1'b1;
                push_idx = IW'(i);
            end
        end
        if (push_vld) begin
            pend_clr[push_idx] = 1'b1;
        end
    end

    assign push_lvl  = plev[push_idx];
    assign push_ok   = push_vld && (cnt != FULL_CNT);
    assign drop      = push_vld && (cnt == FULL_CNT);
    assign pop       = evt_valid && evt_ready;
    assign evt_valid = (cnt != '0);
    assign evt_index = evt_valid ? mem_idx[rd_ptr] : '0;
    assign evt_level = evt_valid ? mem_lvl[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_idx[wr_ptr] <= push_idx;
            mem_lvl[wr_ptr] <= push_lvl;
        end
    end

    // Fullness is judged on the count at cycle start, so a same-cycle pop never rescues a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: tick-number reference model feeds an event scoreboard popped by a negedge monitor.
module tb_sw_debounce;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int FD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic [W-1:0] state_o;
    logic         evt_valid;
    logic         evt_ready;
    logic [2:0]   evt_index;
    logic         evt_level;
    logic         overflow;
    logic         clear_ovf;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .state_o(state_o),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_index(evt_index), .evt_level(evt_level),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    bit armed   = 1'b0;

    // Reference state: switch levels seen two cycles late, tick numbers, pending set, queue occupancy.
    logic [W-1:0] m_state, m_d1, m_d2, m_pend, m_plev;
    int           last_ok [W];
    int           m_tick, m_cyc, m_cnt;
    logic         m_ovf;
    logic [3:0]   sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int   hit;
        bit   pop;
        bit   drop;
        logic smp;
        if (rst) begin
            m_state = '0; m_d1 = '0; m_d2 = '0; m_pend = '0; m_plev = '0;
            for (int i = 0; i < W; i++) last_ok[i] = -1;
            m_tick = 0; m_cyc = 0; m_cnt = 0; m_ovf = 1'b0;
            sbq.delete();
            armed = 1'b1;
        end else begin
            hit  = -1;
            drop = 1'b0;
            pop  = (m_cnt != 0) && evt_ready;
            for (int i = W - 1; i >= 0; i--) if (m_pend[i]) hit = i;
            if (hit >= 0) begin
                m_pend[hit] = 1'b0;
                if (m_cnt < FD) begin
                    m_cnt++;
                    sbq.push_back({3'(hit), m_plev[hit]});
                end else begin
                    drop = 1'b1;
                end
            end
            if (pop) m_cnt--;
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (m_cyc % TD == TD - 1) begin
                for (int i = 0; i < W; i++) begin
                    smp = m_d2[i];
                    if (smp == m_state[i]) begin
                        last_ok[i] = m_tick;
                    end else if (m_tick - last_ok[i] == ST) begin
                        m_state[i] = smp;
                        m_plev[i]  = smp;
                        m_pend[i]  = 1'b1;
                        last_ok[i] = m_tick;
                    end
                end
                m_tick++;
            end
            m_cyc++;
            m_d2 = m_d1;
            m_d1 = sw;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("state_o", 32'(state_o), 32'(m_state));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("evt_valid", 32'(evt_valid), 32'(sbq.size() != 0));
            if (evt_valid && evt_ready && sbq.size() != 0) begin
                chk("evt_index", 32'(evt_index), 32'(sbq[0][3:1]));
                chk("evt_level", 32'(evt_level), 32'(sbq[0][0]));
                void'(sbq.pop_front());
                n_pops++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        int p0;
        int r;
        int idx;
        int rdy_bias;
        rst = 1'b1; sw = '0; evt_ready = 1'b0; clear_ovf = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk("reset_state", 32'(state_o), 32'h0);
        chk("reset_valid", 32'(evt_valid), 32'h0);

        sw = 8'h04;
        cyc(16);
        chk("s1_state", 32'(state_o), 32'h04);
        chk("s1_valid", 32'(evt_valid), 32'h1);
        chk("s1_index", 32'(evt_index), 32'h2);
        chk("s1_level", 32'(evt_level), 32'h1);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("s1_popped", 32'(evt_valid), 32'h0);
        sw = 8'h00; evt_ready = 1'b1;
        cyc(16);
        evt_ready = 1'b0;

        sw = 8'h20;
        cyc(8);
        sw = 8'h00;
        cyc(16);
        chk("s2_state", 32'(state_o), 32'h00);
        chk("s2_valid", 32'(evt_valid), 32'h0);
        chk("s2_ovf", 32'(overflow), 32'h0);

        evt_ready = 1'b1;
        sw = 8'h81;
        cyc(16);
        chk("s3_state", 32'(state_o), 32'h81);
        sw = 8'h00;
        cyc(16);

        evt_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            sw[b] = 1'b1;
            cyc(16);
        end
        chk("s4_ovf", 32'(overflow), 32'h1);
        chk("s4_state", 32'(state_o), 32'h1F);
        chk("s4_head", 32'(evt_index), 32'h0);
        clear_ovf = 1'b1;
        cyc(1);
        clear_ovf = 1'b0;
        chk("s4_clear", 32'(overflow), 32'h0);
        p0 = n_pops;
        evt_ready = 1'b1;
        cyc(6);
        chk("s4_drained", 32'(n_pops - p0), 32'd4);
        chk("s4_empty", 32'(evt_valid), 32'h0);

        sw = 8'h07;
        cyc(16);
        evt_ready = 1'b0;
        sw = 8'h01;
        cyc(16);
        chk("s5_queued", 32'(evt_valid), 32'h1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("s5_state", 32'(state_o), 32'h0);
        chk("s5_valid", 32'(evt_valid), 32'h0);
        k = 0;
        while (!evt_valid && k < 40) begin
            cyc(1);
            k++;
        end
        chk("s5_event_seen", 32'(k < 40), 32'h1);
        chk("s5_index", 32'(evt_index), 32'h0);
        chk("s5_level", 32'(evt_level), 32'h1);
        evt_ready = 1'b1;
        cyc(4);

        evt_ready = 1'b0;
        sw = 8'h1F;
        cyc(16);
        sw = 8'h3F;
        k = 0;
        while (m_pend == '0 && k < 40) begin
            cyc(1);
            k++;
        end
        chk("s6_pend_seen", 32'(k < 40), 32'h1);
        chk("s6_full", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("s6_ovf", 32'(overflow), 32'h1);
        p0 = n_pops;
        evt_ready = 1'b1;
        cyc(6);
        chk("s6_left", 32'(n_pops - p0), 32'd3);
        chk("s6_state", 32'(state_o), 32'h3F);

        rdy_bias = 3;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_bias = $urandom_range(0, 4);
            r = $urandom_range(0, 15);
            if (r == 0) begin
                idx = $urandom_range(0, W - 1);
                sw[idx] = ~sw[idx];
            end else if (r == 1 && $urandom_range(0, 3) == 0) begin
                sw = sw ^ W'($urandom);
            end
            evt_ready = ($urandom_range(0, 3) < rdy_bias);
            clear_ovf = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end

        rst = 1'b0; clear_ovf = 1'b0; evt_ready = 1'b1;
        cyc(40);
        chk("final_scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("final_valid", 32'(evt_valid), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
